// File: rtl/host_bus_responder.sv
// Purpose: host-side cycle controller for the display controller's 8-bit data bus (pin block + 74LVC245).
// Latency: SYNC_STAGES clk input sync, SETTLE_CYCLES before sampling; wr_valid in the cycle sync'd CS release is seen.
// Backpressure: reads wait up to RD_TIMEOUT clk for rd_ack, then return 8'hFF and set sticky err_timeout.
// Optional feature: define HOST_BUS_STATUS_EN to map address {ADDR_W{1'b1}} to a local status register.
module host_bus_responder #(
    parameter int ADDR_W        = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int RD_TIMEOUT    = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              host_cs_n,
    input  logic              host_rw,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        bus_in,
    output logic [7:0]        bus_out,
    output logic              bus_oe,
    output logic              xcvr_dir,
    output logic              xcvr_oe_n,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    input  logic              rd_ack,
    output logic              busy,
    output logic              err_timeout
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TO_W  = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(RD_TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETTLE   = 3'd1;
    localparam logic [2:0] ST_WR_HOLD  = 3'd2;
    localparam logic [2:0] ST_RD_WAIT  = 3'd3;
    localparam logic [2:0] ST_RD_DRIVE = 3'd4;
    localparam logic [2:0] ST_RECOVER  = 3'd5;

    // Synchroniser chains; index SYNC_STAGES-1 is the synchronised output.
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_rw_sync;
    logic [ADDR_W-1:0]      r_addr_sync [SYNC_STAGES];

    logic              w_cs_s;
    logic              w_rw_s;
    logic [ADDR_W-1:0] w_addr_s;

    logic [2:0]        r_state;
    logic              r_cyc_rw;
    logic [SET_W-1:0]  r_settle_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_req;
    logic [7:0]        r_bus_out;
    logic              r_bus_oe;
    logic              r_xcvr_dir;
    logic              r_xcvr_oe_n;
    logic              r_err;

    // Hooks for the local status register; tie-offs when it is not built.
    logic              w_addr_is_stat;
    logic              w_wr_stat;
    logic              w_ack;
    logic [7:0]        w_rdata;

    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_rw_s   = r_rw_sync[SYNC_STAGES-1];
    assign w_addr_s = r_addr_sync[SYNC_STAGES-1];

    // Bring the asynchronous host strobes into the clk domain; CS idles high.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cs_sync <= '1;
            r_rw_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_addr_sync[i] <= '0;
            end
        end else begin
            r_cs_sync      <= {r_cs_sync[SYNC_STAGES-2:0], host_cs_n};
            r_rw_sync      <= {r_rw_sync[SYNC_STAGES-2:0], host_rw};
            r_addr_sync[0] <= host_addr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_addr_sync[i] <= r_addr_sync[i-1];
            end
        end
    end

`ifdef HOST_BUS_STATUS_EN
    localparam logic [ADDR_W-1:0] STAT_ADDR = '1;

    logic       r_busy_seen;
    logic       r_wr_stat;
    logic       r_stat_rd;
    logic [5:0] r_wr_count;
    logic       w_settle_done;
    logic       w_abort;
    logic       w_stat_hit;

    assign w_addr_is_stat = (w_addr_s == STAT_ADDR);
    assign w_wr_stat      = r_wr_stat;
    assign w_ack          = rd_ack | r_stat_rd;
    assign w_rdata        = r_stat_rd ? {r_busy_seen, r_err, r_wr_count} : rd_data;
    assign w_settle_done  = (r_state == ST_SETTLE) && !w_cs_s && (r_settle_cnt == '0);
    assign w_abort        = ((r_state == ST_SETTLE) || (r_state == ST_RD_WAIT)) && w_cs_s;
    assign w_stat_hit     = (r_state == ST_RD_WAIT) && !w_cs_s && r_stat_rd;

    // Status bookkeeping: which cycle targets the status address, aborts seen, writes counted.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_busy_seen <= 1'b0;
            r_wr_stat   <= 1'b0;
            r_stat_rd   <= 1'b0;
            r_wr_count  <= '0;
        end else begin
            if (w_settle_done) begin
                r_wr_stat <= !r_cyc_rw && w_addr_is_stat;
                r_stat_rd <= r_cyc_rw && w_addr_is_stat;
            end else if (r_state == ST_RECOVER) begin
                r_wr_stat <= 1'b0;
                r_stat_rd <= 1'b0;
            end
            if (w_abort) begin
                r_busy_seen <= 1'b1;
            end else if (w_stat_hit) begin
                r_busy_seen <= 1'b0;
            end
            if (wr_valid) begin
                r_wr_count <= r_wr_count + 6'd1;
            end
        end
    end
`else
    assign w_addr_is_stat = 1'b0;
    assign w_wr_stat      = 1'b0;
    assign w_ack          = rd_ack;
    assign w_rdata        = rd_data;
`endif

    // Cycle FSM; pin controls are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= ST_IDLE;
            r_cyc_rw     <= 1'b0;
            r_settle_cnt <= '0;
            r_to_cnt     <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_rd_addr    <= '0;
            r_rd_req     <= 1'b0;
            r_bus_out    <= '0;
            r_bus_oe     <= 1'b0;
            r_xcvr_dir   <= 1'b0;
            r_xcvr_oe_n  <= 1'b1;
            r_err        <= 1'b0;
        end else begin
            r_rd_req <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_cs_s) begin
                        r_cyc_rw     <= w_rw_s;
                        r_settle_cnt <= SET_LOAD;
                        r_state      <= ST_SETTLE;
                        // Reads turn the transceiver early but keep it disabled;
                        // writes enable it at once, direction stays host->FPGA.
                        if (w_rw_s) begin
                            r_xcvr_dir <= 1'b1;
                        end else begin
                            r_xcvr_oe_n <= 1'b0;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (w_cs_s) begin
                        r_xcvr_oe_n <= 1'b1;
                        r_state     <= ST_RECOVER;
                    end else if (r_settle_cnt == '0) begin
                        if (!r_cyc_rw) begin
                            r_wr_addr <= w_addr_s;
                            r_wr_data <= bus_in;
                            r_state   <= ST_WR_HOLD;
                        end else begin
                            r_rd_addr <= w_addr_s;
                            r_rd_req  <= !w_addr_is_stat;
                            r_to_cnt  <= TO_LOAD;
                            r_state   <= ST_RD_WAIT;
                        end
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end
                ST_WR_HOLD: begin
                    if (w_cs_s) begin
                        r_xcvr_oe_n <= 1'b1;
                        r_state     <= ST_RECOVER;
                        if (w_wr_stat) begin
                            r_err <= 1'b0;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    // Host release beats everything; ack beats an expiring counter.
                    if (w_cs_s) begin
                        r_state <= ST_RECOVER;
                    end else if (w_ack) begin
                        r_bus_out   <= w_rdata;
                        r_bus_oe    <= 1'b1;
                        r_xcvr_oe_n <= 1'b0;
                        r_state     <= ST_RD_DRIVE;
                    end else if (r_to_cnt == '0) begin
                        r_bus_out   <= 8'hFF;
                        r_err       <= 1'b1;
                        r_bus_oe    <= 1'b1;
                        r_xcvr_oe_n <= 1'b0;
                        r_state     <= ST_RD_DRIVE;
                    end else begin
                        r_to_cnt <= r_to_cnt - 1'b1;
                    end
                end
                ST_RD_DRIVE: begin
                    if (w_cs_s) begin
                        r_bus_oe    <= 1'b0;
                        r_xcvr_oe_n <= 1'b1;
                        r_state     <= ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    // Transceiver is already disabled here, so direction may flip back.
                    r_xcvr_dir <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_bus_oe    <= 1'b0;
                    r_xcvr_oe_n <= 1'b1;
                    r_state     <= ST_RECOVER;
                end
            endcase
        end
    end

    assign wr_valid    = (r_state == ST_WR_HOLD) && w_cs_s && !w_wr_stat;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign rd_req      = r_rd_req;
    assign rd_addr     = r_rd_addr;
    assign bus_out     = r_bus_out;
    assign bus_oe      = r_bus_oe;
    assign xcvr_dir    = r_xcvr_dir;
    assign xcvr_oe_n   = r_xcvr_oe_n;
    assign busy        = (r_state != ST_IDLE);
    assign err_timeout = r_err;

endmodule

// File: tb/tb_host_bus_responder.sv
// Bench for host_bus_responder: host accesses driven on the falling edge, outputs sampled there too.
// Expected wr/rd strobes go into exp_q as stimulus is issued; observed strobes are popped against them.
module tb_host_bus_responder;

    localparam int ADDR_W = 4;
    localparam int SYNC   = 2;
    localparam int SETTLE = 2;
    localparam int TO     = 8;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              host_cs_n = 1'b1;
    logic              host_rw = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [7:0]        bus_in = '0;
    logic [7:0]        bus_out;
    logic              bus_oe;
    logic              xcvr_dir;
    logic              xcvr_oe_n;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data = '0;
    logic              rd_ack = 1'b0;
    logic              busy;
    logic              err_timeout;

    always #5 clk = ~clk;

    host_bus_responder #(
        .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE), .RD_TIMEOUT(TO)
    ) dut (
        .clk(clk), .nrst(nrst), .host_cs_n(host_cs_n), .host_rw(host_rw), .host_addr(host_addr),
        .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .xcvr_dir(xcvr_dir), .xcvr_oe_n(xcvr_oe_n),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_ack(rd_ack), .busy(busy), .err_timeout(err_timeout)
    );

    typedef struct packed {
        logic              is_rd;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Observations from the last host_access call.
    int         both_cnt, dir_viol, oe_lo_cnt, dir_hi_cnt, boe_cnt, bad_bout;
    int         first_boe_i, rdreq_i, wr_i, dir_lead;
    logic [7:0] boe_val;
    logic       rst_oe, rst_oen, rst_dir, rst_busy;

    // Drives one host access (CS low for cs_len clk), answers rd_req after ack_dly clk
    // (negative = never), optionally pulses reset while the FPGA is driving the bus.
    task automatic host_access(input logic rw, input logic [ADDR_W-1:0] addr, input logic [7:0] wdata,
                               input int cs_len, input int ack_dly, input logic [7:0] rdata,
                               input logic rst_in_drive);
        int   ack_at;
        logic pdir, poen, seen_oe_lo, rst_done;
        both_cnt = 0; dir_viol = 0; oe_lo_cnt = 0; dir_hi_cnt = 0; boe_cnt = 0; bad_bout = 0;
        first_boe_i = -1; rdreq_i = -1; wr_i = -1; dir_lead = 0; boe_val = 8'h00;
        rst_oe = 1'b1; rst_oen = 1'b0; rst_dir = 1'b1; rst_busy = 1'b1;
        ack_at = -1; seen_oe_lo = 1'b0; rst_done = 1'b0;
        @(negedge clk);
        host_rw = rw; host_addr = addr; bus_in = wdata; host_cs_n = 1'b0;
        pdir = xcvr_dir; poen = xcvr_oe_n;
        for (int i = 1; i <= cs_len + 12; i++) begin
            @(negedge clk);
            if (wr_valid && rd_req) both_cnt++;
            if (wr_valid) begin
                obs_q.push_back(ev_t'({1'b0, wr_addr, wr_data}));
                wr_i = i - cs_len;
            end
            if (rd_req) begin
                obs_q.push_back(ev_t'({1'b1, rd_addr, 8'h00}));
                rdreq_i = i;
                if (ack_dly >= 0) ack_at = i + ack_dly;
            end
            if ((xcvr_dir !== pdir) && (!xcvr_oe_n || !poen)) dir_viol++;
            if (!xcvr_oe_n) begin oe_lo_cnt++; seen_oe_lo = 1'b1; end
            if (xcvr_dir) dir_hi_cnt++;
            if (xcvr_dir && xcvr_oe_n && !seen_oe_lo) dir_lead++;
            if (bus_oe) begin
                boe_cnt++;
                if (first_boe_i < 0) begin first_boe_i = i; boe_val = bus_out; end
                else if (bus_out !== boe_val) bad_bout++;
            end
            pdir = xcvr_dir; poen = xcvr_oe_n;
            rd_ack  = (i == ack_at);
            rd_data = (i == ack_at) ? rdata : 8'h00;
            if (i == cs_len) host_cs_n = 1'b1;
            if (rst_in_drive && bus_oe && !rst_done) begin
                rst_done = 1'b1;
                #2 nrst = 1'b0;
                #1 rst_oe = bus_oe; rst_oen = xcvr_oe_n; rst_dir = xcvr_dir; rst_busy = busy;
                host_cs_n = 1'b1; rd_ack = 1'b0; ack_at = -1;
                #1 nrst = 1'b1;
                pdir = xcvr_dir; poen = xcvr_oe_n;
            end
        end
        rd_ack = 1'b0;
    endtask

    task automatic test_reset;
        logic [34:0] got, want;
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        got  = {bus_out, bus_oe, xcvr_dir, xcvr_oe_n, wr_valid, rd_req, wr_addr, wr_data, rd_addr, busy, err_timeout};
        want = {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0};
        n_checks++;
        if (got !== want) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", got, want); end
        nrst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write;
        ev_t e, o;
        exp_q.push_back(ev_t'({1'b0, 4'h3, 8'hA5}));
        host_access(1'b0, 4'h3, 8'hA5, 10, -1, 8'h00, 1'b0);
        e = exp_q.pop_front();
        n_checks++;
        if (obs_q.size() == 0) begin n_fail++; $display("FAIL wr_sb: got none want %h", e); end
        else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL wr_sb: got %h want %h", o, e); end end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL wr_extra: got %0d want 0", obs_q.size()); end
        obs_q.delete();
        n_checks++; if (wr_i != SYNC) begin n_fail++; $display("FAIL wr_latency: got %0d want %0d", wr_i, SYNC); end
        n_checks++; if (dir_hi_cnt != 0) begin n_fail++; $display("FAIL wr_dir: got %0d want 0", dir_hi_cnt); end
        // oe_n low from sync'd CS fall + 1 until sync'd CS rise + 1: exactly the CS width.
        n_checks++; if (oe_lo_cnt != 10) begin n_fail++; $display("FAIL wr_oe_len: got %0d want 10", oe_lo_cnt); end
        n_checks++; if ({both_cnt, dir_viol} != 0) begin n_fail++; $display("FAIL wr_rules: got both=%0d dirv=%0d want 0", both_cnt, dir_viol); end
        n_checks++; if ({busy, xcvr_oe_n, bus_oe} !== 3'b010) begin n_fail++; $display("FAIL wr_idle: got %b want 010", {busy, xcvr_oe_n, bus_oe}); end
    endtask

    task automatic test_read_ack;
        ev_t e, o;
        exp_q.push_back(ev_t'({1'b1, 4'h7, 8'h00}));
        host_access(1'b1, 4'h7, 8'h00, 14, 3, 8'h5C, 1'b0);
        e = exp_q.pop_front();
        n_checks++;
        if (obs_q.size() == 0) begin n_fail++; $display("FAIL rd_sb: got none want %h", e); end
        else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL rd_sb: got %h want %h", o, e); end end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rd_extra: got %0d want 0", obs_q.size()); end
        obs_q.delete();
        n_checks++; if (boe_val !== 8'h5C || bad_bout != 0) begin n_fail++; $display("FAIL rd_data: got %h bad=%0d want 5c", boe_val, bad_bout); end
        // Ack seen 3 clk after rd_req, registered one edge later.
        n_checks++; if (first_boe_i - rdreq_i != 4) begin n_fail++; $display("FAIL rd_ack_lat: got %0d want 4", first_boe_i - rdreq_i); end
        // bus_oe from sample 9 until sync'd CS release + 1 (14+2+1=17): 8 samples.
        n_checks++; if (boe_cnt != 8) begin n_fail++; $display("FAIL rd_oe_len: got %0d want 8", boe_cnt); end
        n_checks++; if (dir_lead < 2) begin n_fail++; $display("FAIL rd_dir_lead: got %0d want >=2", dir_lead); end
        n_checks++; if (dir_viol != 0) begin n_fail++; $display("FAIL rd_dir_flip: got %0d want 0", dir_viol); end
        n_checks++; if ({busy, xcvr_dir, xcvr_oe_n, bus_oe, err_timeout} !== 5'b00100) begin n_fail++; $display("FAIL rd_idle: got %b want 00100", {busy, xcvr_dir, xcvr_oe_n, bus_oe, err_timeout}); end
    endtask

    task automatic test_ack_at_expiry;
        ev_t e, o;
        exp_q.push_back(ev_t'({1'b1, 4'hB, 8'h00}));
        host_access(1'b1, 4'hB, 8'h00, 20, TO - 1, 8'hC3, 1'b0);
        e = exp_q.pop_front();
        n_checks++;
        if (obs_q.size() == 0) begin n_fail++; $display("FAIL exp_sb: got none want %h", e); end
        else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL exp_sb: got %h want %h", o, e); end end
        obs_q.delete();
        n_checks++; if (first_boe_i - rdreq_i != TO) begin n_fail++; $display("FAIL exp_lat: got %0d want %0d", first_boe_i - rdreq_i, TO); end
        n_checks++; if (boe_val !== 8'hC3 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL exp_ack_wins: got %h err=%b want c3 err=0", boe_val, err_timeout); end
    endtask

    task automatic test_read_abort;
        ev_t e, o;
        exp_q.push_back(ev_t'({1'b1, 4'h4, 8'h00}));
        host_access(1'b1, 4'h4, 8'h00, 6, 10, 8'h99, 1'b0);
        e = exp_q.pop_front();
        n_checks++;
        if (obs_q.size() == 0) begin n_fail++; $display("FAIL abort_sb: got none want %h", e); end
        else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL abort_sb: got %h want %h", o, e); end end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL abort_extra: got %0d want 0", obs_q.size()); end
        obs_q.delete();
        n_checks++; if (boe_cnt != 0 || busy !== 1'b0 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL abort_state: got oe=%0d busy=%b err=%b want 0 0 0", boe_cnt, busy, err_timeout); end
    endtask

    task automatic test_glitch;
        host_access(1'b0, 4'h2, 8'h11, 1, -1, 8'h00, 1'b0);
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch_strobe: got %0d want 0", obs_q.size()); end
        obs_q.delete();
        n_checks++; if (oe_lo_cnt != 1 || xcvr_oe_n !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL glitch_state: got oelo=%0d oe_n=%b busy=%b want 1 1 0", oe_lo_cnt, xcvr_oe_n, busy); end
    endtask

    task automatic test_timeout;
        ev_t e, o;
        exp_q.push_back(ev_t'({1'b1, 4'h9, 8'h00}));
        exp_q.push_back(ev_t'({1'b0, 4'h1, 8'h3E}));
        host_access(1'b1, 4'h9, 8'h00, 20, -1, 8'h00, 1'b0);
        n_checks++; if (first_boe_i - rdreq_i != TO) begin n_fail++; $display("FAIL to_lat: got %0d want %0d", first_boe_i - rdreq_i, TO); end
        n_checks++; if (boe_val !== 8'hFF || err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_value: got %h err=%b want ff err=1", boe_val, err_timeout); end
        host_access(1'b0, 4'h1, 8'h3E, 8, -1, 8'h00, 1'b0);
        n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", err_timeout); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL to_sb: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL to_sb: got %h want %h", o, e); end end
        end
        obs_q.delete();
    endtask

    task automatic test_reset_in_drive;
        ev_t e, o;
        exp_q.push_back(ev_t'({1'b1, 4'h6, 8'h00}));
        host_access(1'b1, 4'h6, 8'h00, 30, 1, 8'h77, 1'b1);
        n_checks++; if ({rst_oe, rst_oen, rst_dir, rst_busy} !== 4'b0100) begin n_fail++; $display("FAIL rst_drive: got %b want 0100", {rst_oe, rst_oen, rst_dir, rst_busy}); end
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err_timeout); end
        exp_q.push_back(ev_t'({1'b1, 4'h7, 8'h00}));
        host_access(1'b1, 4'h7, 8'h00, 14, 3, 8'h3C, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL rst_sb: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL rst_sb: got %h want %h", o, e); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rst_extra: got %0d want 0", obs_q.size()); end
        obs_q.delete();
        n_checks++; if (boe_val !== 8'h3C || boe_cnt != 8) begin n_fail++; $display("FAIL rst_next_rd: got %h cnt=%0d want 3c 8", boe_val, boe_cnt); end
    endtask

`ifdef HOST_BUS_STATUS_EN
    task automatic test_status;
        ev_t e, o;
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(ev_t'({1'b0, 4'h2, 8'h40 + 8'(k)}));
            host_access(1'b0, 4'h2, 8'h40 + 8'(k), 8, -1, 8'h00, 1'b0);
        end
        host_access(1'b1, 4'hF, 8'h00, 14, -1, 8'h00, 1'b0);
        n_checks++; if (boe_val !== 8'h03 || rdreq_i != -1) begin n_fail++; $display("FAIL stat_read: got %h rdreq@%0d want 03 none", boe_val, rdreq_i); end
        exp_q.push_back(ev_t'({1'b1, 4'h5, 8'h00}));
        host_access(1'b1, 4'h5, 8'h00, 20, -1, 8'h00, 1'b0);
        n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL stat_err_set: got %b want 1", err_timeout); end
        host_access(1'b0, 4'hF, 8'h00, 8, -1, 8'h00, 1'b0);
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL stat_err_clr: got %b want 0", err_timeout); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL stat_sb: got none want %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL stat_sb: got %h want %h", o, e); end end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL stat_extra: got %0d want 0", obs_q.size()); end
        obs_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read_ack();
        test_ack_at_expiry();
        test_read_abort();
        test_glitch();
        test_timeout();
        test_reset_in_drive();
`ifdef HOST_BUS_STATUS_EN
        test_status();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
